bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single addr/data bus of `design` among NREQ requesters. Each requester presents one transaction (addr, data, write flag) and holds `req` until acknowledged. The arbiter latches the winner, drives it onto the downstream valid/ready bus and returns a per-requester ack or error pulse. It sits between the env-side request agents and the `design` bus port on `intf`.

---
 rtl/bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one valid/ready bus
// among NREQ requesters. One transaction is latched per grant, issued until
// handshake or timeout, and answered with a one-cycle ack or err pulse.
module bus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic [NREQ-1:0]          req_wr,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          err,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [AW-1:0]            bus_addr,
    output logic [DW-1:0]            bus_data,
    output logic                     bus_wr,
    output logic [$clog2(NREQ)-1:0]  bus_id,
    output logic                     busy,
    output logic [15:0]              txn_count
);

    localparam int unsigned IDW = $clog2(NREQ);
    // Wait counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    last_q,  last_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [AW-1:0]     addr_q,  addr_d;
    logic [DW-1:0]     data_q,  data_d;
    logic              wr_q,    wr_d;
    logic [IDW-1:0]    id_q,    id_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic [NREQ-1:0]   err_q,   err_d;
    logic [15:0]       txn_q,   txn_d;

    logic              grant_found_c;
    logic [IDW-1:0]    grant_idx_c;
    logic              handshake_c;
    logic              timeout_c;

    // Round-robin pick: first requester at or after (last+1) mod NREQ.
    always_comb begin : rr_pick
        int unsigned idx;
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        idx           = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!grant_found_c && req[IDW'(idx)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = IDW'(idx);
            end
        end
    end

    // Completion conditions while issuing; ready wins over timeout.
    always_comb begin
        handshake_c = (state_q == S_ISSUE) && bus_ready;
        timeout_c   = (TIMEOUT != 0) && (state_q == S_ISSUE) && !bus_ready &&
                      (cnt_q == CW'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found_c) state_d = S_ISSUE;
            S_ISSUE: if (handshake_c || timeout_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; all results land in flops.
    always_comb begin
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        id_d    = id_q;
        txn_d   = txn_q;
        ack_d   = '0;
        err_d   = '0;
        valid_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (grant_found_c) begin
                    addr_d = req_addr[32'(grant_idx_c) * AW +: AW];
                    data_d = req_data[32'(grant_idx_c) * DW +: DW];
                    wr_d   = req_wr[grant_idx_c];
                    id_d   = grant_idx_c;
                    cnt_d  = '0;
                end
            end
            S_ISSUE: begin
                if (handshake_c) begin
                    ack_d[id_q] = 1'b1;
                    last_d      = id_q;
                    if (txn_q != 16'hFFFF) begin
                        txn_d = txn_q + 16'd1;
                    end
                end else if (timeout_c) begin
                    err_d[id_q] = 1'b1;
                    last_d      = id_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= IDW'(NREQ - 1);
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            id_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            txn_q   <= '0;
        end else begin
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    assign bus_valid = valid_q;
    assign bus_addr  = addr_q;
    assign bus_data  = data_q;
    assign bus_wr    = wr_q;
    assign bus_id    = id_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: table-driven contention run plus
// hand-written single, fairness, backpressure, timeout and reset sequences.
module tb_bus_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned AW      = 64;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_wr;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     err;
    logic                bus_valid;
    logic                bus_ready;
    logic [AW-1:0]       bus_addr;
    logic [DW-1:0]       bus_data;
    logic                bus_wr;
    logic [1:0]          bus_id;
    logic                busy;
    logic [15:0]         txn_count;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_wr    (req_wr),
        .ack       (ack),
        .err       (err),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_wr    (bus_wr),
        .bus_id    (bus_id),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic        valid;
        logic [1:0]  id;
        logic [3:0]  ack;
        logic        busy;
        logic [15:0] txn;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_addr(input int i);
        return {32'hA000_0000, 32'(i)};
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    function automatic logic exp_wr(input int i);
        return 1'(i & 1);
    endfunction

    task automatic set_ops();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_addr[i*AW +: AW] = exp_addr(i);
            req_data[i*DW +: DW] = exp_data(i);
            req_wr[i]            = exp_wr(i);
        end
    endtask

    task automatic chk_ops(input string name, input int i);
        chk({name, " addr"}, bus_addr, exp_addr(i));
        chk({name, " data"}, 64'(bus_data), 64'(exp_data(i)));
        chk({name, " wr"},   64'(bus_wr), 64'(exp_wr(i)));
        chk({name, " id"},   64'(bus_id), 64'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] txn_before;

        vecs[0]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 16'd0};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 16'd1};
        vecs[2]  = '{4'b1110, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 16'd1};
        vecs[3]  = '{4'b1110, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 16'd1};
        vecs[4]  = '{4'b1110, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1, 16'd2};
        vecs[5]  = '{4'b1100, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 16'd2};
        vecs[6]  = '{4'b1100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1, 16'd2};
        vecs[7]  = '{4'b1100, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 16'd3};
        vecs[8]  = '{4'b1000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 16'd3};
        vecs[9]  = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b1, 16'd3};
        vecs[10] = '{4'b1000, 1'b1, 1'b0, 2'd3, 4'b1000, 1'b1, 16'd4};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 16'd4};
        vecs[12] = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 16'd4};

        // Reset state
        rst = 1'b0;
        req = '0;
        bus_ready = 1'b0;
        set_ops();
        #2;
        chk("reset valid", 64'(bus_valid), 64'd0);
        repeat (3) tick();
        chk("reset valid2", 64'(bus_valid), 64'd0);
        chk("reset busy",   64'(busy), 64'd0);
        chk("reset ack",    64'(ack), 64'd0);
        chk("reset err",    64'(err), 64'd0);
        chk("reset addr",   bus_addr, 64'd0);
        chk("reset txn",    64'(txn_count), 64'd0);

        // Contention from reset, table-driven
        rst = 1'b1;
        for (int v = 0; v < 13; v++) begin
            req       = vecs[v].req;
            bus_ready = vecs[v].rdy;
            tick();
            chk($sformatf("cont[%0d] valid", v), 64'(bus_valid), 64'(vecs[v].valid));
            chk($sformatf("cont[%0d] ack", v),   64'(ack), 64'(vecs[v].ack));
            chk($sformatf("cont[%0d] err", v),   64'(err), 64'd0);
            chk($sformatf("cont[%0d] busy", v),  64'(busy), 64'(vecs[v].busy));
            chk($sformatf("cont[%0d] txn", v),   64'(txn_count), 64'(vecs[v].txn));
            if (vecs[v].valid)
                chk_ops($sformatf("cont[%0d]", v), int'(vecs[v].id));
        end

        // Single request on requester 2
        req_addr[2*AW +: AW] = 64'h0000_0000_DEAD_BEEF;
        req_data[2*DW +: DW] = 32'h1234_5678;
        req_wr[2] = 1'b1;
        req = 4'b0100;
        tick();
        chk("single valid", 64'(bus_valid), 64'd1);
        chk("single addr",  bus_addr, 64'h0000_0000_DEAD_BEEF);
        chk("single data",  64'(bus_data), 64'h1234_5678);
        chk("single wr",    64'(bus_wr), 64'd1);
        chk("single id",    64'(bus_id), 64'd2);
        tick();
        chk("single valid off", 64'(bus_valid), 64'd0);
        chk("single ack",   64'(ack), 64'b0100);
        chk("single txn",   64'(txn_count), 64'd5);
        req = 4'b0000;
        set_ops();
        tick();
        chk("single ack off", 64'(ack), 64'd0);

        // Fairness: after id 2, requesters 1 and 3 together -> 3 first
        req = 4'b1010;
        tick();
        chk("fair first id", 64'(bus_id), 64'd3);
        chk("fair first valid", 64'(bus_valid), 64'd1);
        tick();
        chk("fair first ack", 64'(ack), 64'b1000);
        req = 4'b0010;
        tick();
        tick();
        chk("fair second id", 64'(bus_id), 64'd1);
        chk("fair second valid", 64'(bus_valid), 64'd1);
        tick();
        chk("fair second ack", 64'(ack), 64'b0010);
        chk("fair txn", 64'(txn_count), 64'd7);
        req = 4'b0000;
        tick();

        // Backpressure: ready low for 5 issue cycles, then high
        req = 4'b0001;
        bus_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp valid c%0d", i + 1), 64'(bus_valid), 64'd1);
            chk_ops($sformatf("bp c%0d", i + 1), 0);
            if (i == 1) req_addr[0 +: AW] = 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
        end
        chk("bp valid c6", 64'(bus_valid), 64'd1);
        chk_ops("bp c6", 0);
        bus_ready = 1'b1;
        tick();
        chk("bp ack", 64'(ack), 64'b0001);
        chk("bp err", 64'(err), 64'd0);
        chk("bp valid off", 64'(bus_valid), 64'd0);
        req = 4'b0000;
        set_ops();
        tick();

        // Timeout: ready held low on requester 1
        txn_before = txn_count;
        req = 4'b0010;
        bus_ready = 1'b0;
        tick();
        n = 0;
        for (int i = 0; i < 40 && bus_valid; i++) begin
            n++;
            if (bus_id !== 2'd1) chk("to id", 64'(bus_id), 64'd1);
            tick();
        end
        chk("to valid cycles", 64'(n), 64'(TIMEOUT));
        chk("to err", 64'(err), 64'b0010);
        chk("to ack", 64'(ack), 64'd0);
        chk("to txn", 64'(txn_count), 64'(txn_before));
        req = 4'b0000;
        tick();
        chk("to err off", 64'(err), 64'd0);
        // Next requester served normally; pointer moved past 1
        req = 4'b0101;
        bus_ready = 1'b1;
        tick();
        chk("post-to id", 64'(bus_id), 64'd2);
        chk("post-to valid", 64'(bus_valid), 64'd1);
        tick();
        chk("post-to ack", 64'(ack), 64'b0100);
        req = 4'b0000;
        tick();

        // Reset mid-issue during backpressure
        req = 4'b0001;
        bus_ready = 1'b0;
        tick();
        tick();
        chk("rst pre valid", 64'(bus_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst valid", 64'(bus_valid), 64'd0);
        chk("rst busy",  64'(busy), 64'd0);
        chk("rst txn",   64'(txn_count), 64'd0);
        chk("rst addr",  bus_addr, 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst ack c%0d", i), 64'(ack), 64'd0);
            chk($sformatf("rst err c%0d", i), 64'(err), 64'd0);
        end
        req = 4'b1111;
        bus_ready = 1'b1;
        rst = 1'b1;
        tick();
        chk("rel id", 64'(bus_id), 64'd0);
        chk("rel valid", 64'(bus_valid), 64'd1);
        tick();
        chk("rel ack", 64'(ack), 64'b0001);
        chk("rel err", 64'(err), 64'd0);
        chk("rel txn", 64'(txn_count), 64'd1);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
